// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder/subtractor.
// Operands are captured on an input handshake and added CHUNK bits per
// clock, least-significant chunk first. The result (sum, carry-out and
// signed overflow) is presented with a valid/ready handshake and held
// stable until the consumer accepts it, then kept visible while idle.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep the index at least one bit wide so NCHUNK = 1 still elaborates.
    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [IDXW-1:0]  idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_res_s;
    logic             msb_cin_s;
    logic             last_s;

    // One chunk of the ripple: CHUNK-bit add with carry-in, carry-out on top.
    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    // Select the active chunk, add it, and derive the carry into its MSB.
    always_comb begin
        a_chunk_s   = a_r[idx_r*CHUNK +: CHUNK];
        b_chunk_s   = b_r[idx_r*CHUNK +: CHUNK];
        chunk_res_s = chunk_add(a_chunk_s, b_chunk_s, carry_r);
        // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ c.
        msb_cin_s   = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ chunk_res_s[CHUNK-1];
        last_s      = (idx_r == LAST_IDX);
    end

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE handshake flow.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand capture, per-chunk accumulation and final flag computation.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, so invert b and force carry-in.
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r[idx_r*CHUNK +: CHUNK] <= chunk_res_s[CHUNK-1:0];
                    carry_r                     <= chunk_res_s[CHUNK];
                    if (last_s) begin
                        cout_r <= chunk_res_s[CHUNK];
                        ovf_r  <= msb_cin_s ^ chunk_res_s[CHUNK];
                        idx_r  <= '0;
                    end else begin
                        idx_r  <= idx_r + IDXW'(1);
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it.
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule
